// File: rtl/ex_muldiv.sv
// ex_muldiv: RV32M multiply/divide unit for the EX stage. It runs an iterative
// radix-2 shift-add multiplier and restoring divider over operand magnitudes.
// Latency: 33 cycles from the accepting edge to done_o. Divide-by-zero and
// signed overflow finish in 1 cycle. stall_o holds the pipeline while the op is
// accepted or busy. Optional feature: define MULDIV_DIV_EN to build the divider
// (DIV/DIVU/REM/REMU); without it those encodings are ignored as non-M.
module ex_muldiv (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        valid_i,
  input  logic        flush_i,
  input  logic [9:0]  funct_i,
  input  logic [31:0] RS1Data_i,
  input  logic [31:0] RS2Data_i,
  input  logic [4:0]  Rd_Addr_i,
  output logic        stall_o,
  output logic        done_o,
  output logic [31:0] result_o,
  output logic [4:0]  Rd_Addr_o
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  localparam logic [2:0] F_MUL    = 3'b000;
  localparam logic [2:0] F_MULH   = 3'b001;
  localparam logic [2:0] F_MULHSU = 3'b010;
  localparam logic [2:0] F_DIV    = 3'b100;
  localparam logic [2:0] F_REM    = 3'b110;

  state_t      state_q;
  logic [4:0]  cnt_q;
  logic [1:0]  op_q;       // funct3[1:0] of the op in flight
  logic        neg_q;      // final result must be negated
  logic [63:0] prod_q;     // {high/remainder, low/multiplier-quotient}
  logic [31:0] b_q;        // magnitude of operand B
  logic [4:0]  rd_q;
  logic [31:0] result_q;
  logic [4:0]  rd_out_q;

  logic [2:0]  f3;
  logic        is_mop;
  logic        accept;
  logic        a_signed, b_signed, a_neg, b_neg, neg_in;
  logic [31:0] a_mag, b_mag;
  logic [32:0] mul_sum;
  logic [63:0] mul_nxt, step_nxt, prod_fix;
  logic [31:0] busy_res;

`ifdef MULDIV_DIV_EN
  logic        div_q;
  logic        div_zero, div_ovf, special_hit;
  logic [31:0] special_res;
  logic [33:0] div_diff;
  logic [63:0] div_nxt;
  logic [31:0] div_sel;
`endif

  // Decode the ID/EX instruction and form operand magnitudes and the result sign
  always_comb begin
    f3 = funct_i[2:0];
`ifdef MULDIV_DIV_EN
    is_mop = (funct_i[9:3] == 7'b0000001);
`else
    is_mop = (funct_i[9:3] == 7'b0000001) && !funct_i[2];
`endif
    accept   = (state_q == S_IDLE) && valid_i && is_mop && !flush_i;
    a_signed = (f3 == F_MULH) || (f3 == F_MULHSU) || (f3 == F_DIV) || (f3 == F_REM);
    b_signed = (f3 == F_MULH) || (f3 == F_DIV) || (f3 == F_REM);
    a_neg    = a_signed && RS1Data_i[31];
    b_neg    = b_signed && RS2Data_i[31];
    a_mag    = a_neg ? (32'd0 - RS1Data_i) : RS1Data_i;
    b_mag    = b_neg ? (32'd0 - RS2Data_i) : RS2Data_i;
    // Remainder takes the dividend's sign; products and quotients the XOR of signs
    neg_in   = (f3 == F_REM) ? a_neg : (a_neg ^ b_neg);
  end

`ifdef MULDIV_DIV_EN
  // Divide corner cases that bypass the iterative datapath
  always_comb begin
    div_zero    = (RS2Data_i == 32'd0);
    div_ovf     = !f3[0] && (RS1Data_i == 32'h8000_0000) && (RS2Data_i == 32'hFFFF_FFFF);
    special_hit = f3[2] && (div_zero || div_ovf);
    if (f3[1]) begin
      special_res = div_zero ? RS1Data_i : 32'd0;
    end else begin
      special_res = div_zero ? 32'hFFFF_FFFF : 32'h8000_0000;
    end
  end
`endif

  // One iteration of the datapath: shift-add multiply, restoring divide
  always_comb begin
    mul_sum  = {1'b0, prod_q[63:32]} + (prod_q[0] ? {1'b0, b_q} : 33'd0);
    mul_nxt  = {mul_sum, prod_q[31:1]};
    step_nxt = mul_nxt;
`ifdef MULDIV_DIV_EN
    div_diff = {1'b0, prod_q[63:31]} - {2'b00, b_q};
    if (div_diff[33]) begin
      div_nxt = {prod_q[62:0], 1'b0};
    end else begin
      div_nxt = {div_diff[31:0], prod_q[30:0], 1'b1};
    end
    if (div_q) begin
      step_nxt = div_nxt;
    end
`endif
  end

  // Sign correction and result selection applied to the last iteration's output
  always_comb begin
    prod_fix = neg_q ? (64'd0 - step_nxt) : step_nxt;
    busy_res = (op_q == F_MUL[1:0]) ? prod_fix[31:0] : prod_fix[63:32];
`ifdef MULDIV_DIV_EN
    div_sel = op_q[1] ? step_nxt[63:32] : step_nxt[31:0];
    if (div_q) begin
      busy_res = neg_q ? (32'd0 - div_sel) : div_sel;
    end
`endif
  end

  // Control FSM and datapath registers; flush aborts without touching the result
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      cnt_q    <= 5'd0;
      op_q     <= 2'd0;
      neg_q    <= 1'b0;
      prod_q   <= 64'd0;
      b_q      <= 32'd0;
      rd_q     <= 5'd0;
      result_q <= 32'd0;
      rd_out_q <= 5'd0;
`ifdef MULDIV_DIV_EN
      div_q    <= 1'b0;
`endif
    end else if (flush_i) begin
      state_q <= S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            op_q   <= f3[1:0];
            neg_q  <= neg_in;
            prod_q <= {32'd0, a_mag};
            b_q    <= b_mag;
            rd_q   <= Rd_Addr_i;
            cnt_q  <= 5'd0;
            state_q <= S_BUSY;
`ifdef MULDIV_DIV_EN
            div_q  <= f3[2];
            if (special_hit) begin
              result_q <= special_res;
              rd_out_q <= Rd_Addr_i;
              state_q  <= S_DONE;
            end
`endif
          end
        end
        S_BUSY: begin
          prod_q <= step_nxt;
          cnt_q  <= cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            result_q <= busy_res;
            rd_out_q <= rd_q;
            state_q  <= S_DONE;
          end
        end
        S_DONE: begin
          // The instruction is still in ID/EX this cycle, so it must not re-issue
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Outputs: stall covers the accepting cycle and every busy cycle
  always_comb begin
    stall_o   = !rst_i && (accept || (state_q == S_BUSY));
    done_o    = (state_q == S_DONE);
    result_o  = result_q;
    Rd_Addr_o = rd_out_q;
  end

endmodule

// File: tb/tb_ex_muldiv.sv
// Bench for ex_muldiv: transaction-level reference model plus per-cycle compare,
// directed literal cases, and randomized instruction streams.
module tb_ex_muldiv;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        valid_i, flush_i;
  logic [9:0]  funct_i;
  logic [31:0] RS1Data_i, RS2Data_i;
  logic [4:0]  Rd_Addr_i;
  logic        stall_o, done_o;
  logic [31:0] result_o;
  logic [4:0]  Rd_Addr_o;

`ifdef MULDIV_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  ex_muldiv dut (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .flush_i(flush_i),
    .funct_i(funct_i), .RS1Data_i(RS1Data_i), .RS2Data_i(RS2Data_i),
    .Rd_Addr_i(Rd_Addr_i), .stall_o(stall_o), .done_o(done_o),
    .result_o(result_o), .Rd_Addr_o(Rd_Addr_o)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Architectural result of an RV32M op, from plain integer arithmetic
  function automatic logic [31:0] ref_res(input logic [2:0] f3, input logic [31:0] a,
                                          input logic [31:0] b);
    longint      sa, sb, sub;
    logic [63:0] ua, ub, p;
    int          ia, ib;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    sub = longint'({32'd0, b});
    ua  = {32'd0, a};
    ub  = {32'd0, b};
    ia  = $signed(a);
    ib  = $signed(b);
    case (f3)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = 64'(sa * sb); return p[63:32]; end
      3'd2: begin p = 64'(sa * sub); return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        return 32'(ia / ib);
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return 32'(ia % ib);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic bit is_mop(input logic [9:0] f);
    return (f[9:3] == 7'b0000001) && (DIV_EN || !f[2]);
  endfunction

  function automatic bit fast_op(input logic [2:0] f3, input logic [31:0] a,
                                 input logic [31:0] b);
    return f3[2] && ((b == 0) || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  // Reference model: cycles left until the result appears, plus the held result
  int          busy_left = 0;
  bit          m_done = 1'b0;
  logic [31:0] m_res = '0, exp_res = '0;
  logic [4:0]  m_rd = '0, exp_rd = '0;

  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      busy_left <= 0;
      m_done    <= 1'b0;
      m_res     <= '0;
      m_rd      <= '0;
    end else if (flush_i) begin
      busy_left <= 0;
      m_done    <= 1'b0;
    end else if (m_done) begin
      m_done <= 1'b0;
    end else if (busy_left > 0) begin
      busy_left <= busy_left - 1;
      if (busy_left == 1) begin
        m_done <= 1'b1;
        m_res  <= exp_res;
        m_rd   <= exp_rd;
      end
    end else if (valid_i && is_mop(funct_i)) begin
      if (fast_op(funct_i[2:0], RS1Data_i, RS2Data_i)) begin
        m_done <= 1'b1;
        m_res  <= ref_res(funct_i[2:0], RS1Data_i, RS2Data_i);
        m_rd   <= Rd_Addr_i;
      end else begin
        busy_left <= 32;
        exp_res   <= ref_res(funct_i[2:0], RS1Data_i, RS2Data_i);
        exp_rd    <= Rd_Addr_i;
      end
    end
  end

  // Per-cycle comparison of every output against the model
  always @(negedge clk_i) begin
    bit e_stall;
    e_stall = !rst_i && ((busy_left > 0) ||
              (!m_done && valid_i && !flush_i && is_mop(funct_i)));
    chk("cyc stall_o", 32'(stall_o), 32'(e_stall));
    chk("cyc done_o", 32'(done_o), 32'(m_done));
    chk("cyc result_o", result_o, m_res);
    chk("cyc Rd_Addr_o", 32'(Rd_Addr_o), 32'(m_rd));
  end

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  task automatic drive(input bit v, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd);
    valid_i   = v;
    funct_i   = {7'b0000001, f3};
    RS1Data_i = a;
    RS2Data_i = b;
    Rd_Addr_i = rd;
    flush_i   = 1'b0;
  endtask

  // Issue an op, hold it while stalled, and check latency, stall length and result
  task automatic run_op(input string nm, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd,
                        input logic [31:0] exp_r, input int exp_lat);
    int k;
    int stalls;
    bit seen;
    @(posedge clk_i); #1;
    drive(1'b1, f3, a, b, rd);
    k = 0; stalls = 0; seen = 1'b0;
    while (!seen && k < 50) begin
      @(negedge clk_i);
      if (stall_o) stalls++;
      if (done_o) seen = 1'b1;
      else begin
        @(posedge clk_i); #1;
        k++;
      end
    end
    chk({nm, " done seen"}, 32'(seen), 32'd1);
    chk({nm, " latency"}, 32'(k), 32'(exp_lat));
    chk({nm, " stall cycles"}, 32'(stalls), 32'(exp_lat));
    chk({nm, " result"}, result_o, exp_r);
    chk({nm, " rd"}, 32'(Rd_Addr_o), 32'(rd));
    @(posedge clk_i); #1;
    valid_i = 1'b0;
  endtask

  initial begin
    int activity;
    drive(1'b0, 3'd0, 32'd0, 32'd0, 5'd0);
    #1 rst_i = 1'b1;
    repeat (2) @(negedge clk_i);
    chk("reset stall_o", 32'(stall_o), 32'd0);
    chk("reset done_o", 32'(done_o), 32'd0);
    chk("reset result_o", result_o, 32'd0);
    chk("reset Rd_Addr_o", 32'(Rd_Addr_o), 32'd0);
    @(posedge clk_i); #1 rst_i = 1'b0;

    run_op("MUL 7x6", 3'd0, 32'd7, 32'd6, 5'd5, 32'd42, 33);
    run_op("MULH -1x-1", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, 32'h0000_0000, 33);
    run_op("MULHU max", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 32'hFFFF_FFFE, 33);
    run_op("MULHSU -1x2", 3'd2, 32'hFFFF_FFFF, 32'd2, 5'd8, 32'hFFFF_FFFF, 33);
    run_op("MUL -3x5", 3'd0, 32'hFFFF_FFFD, 32'd5, 5'd9, 32'hFFFF_FFF1, 33);
`ifdef MULDIV_DIV_EN
    run_op("DIV -7/2", 3'd4, 32'hFFFF_FFF9, 32'd2, 5'd10, 32'hFFFF_FFFD, 33);
    run_op("REM -7/2", 3'd6, 32'hFFFF_FFF9, 32'd2, 5'd11, 32'hFFFF_FFFF, 33);
    run_op("DIVU 100/0", 3'd5, 32'd100, 32'd0, 5'd12, 32'hFFFF_FFFF, 1);
    run_op("REMU 100/0", 3'd7, 32'd100, 32'd0, 5'd13, 32'd100, 1);
    run_op("DIV ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'h8000_0000, 1);
`else
    // Divide encodings behave as non-M instructions
    @(posedge clk_i); #1;
    drive(1'b1, 3'd4, 32'd10, 32'd2, 5'd10);
    activity = 0;
    repeat (40) begin
      @(negedge clk_i);
      if (stall_o || done_o) activity++;
    end
    chk("DIV disabled activity", 32'(activity), 32'd0);
    chk("DIV disabled result", result_o, 32'hFFFF_FFF1);
    @(posedge clk_i); #1 valid_i = 1'b0;
`endif

    // Flush in the 5th busy cycle: no done_o, result unchanged
    run_op("MUL 3x4", 3'd0, 32'd3, 32'd4, 5'd15, 32'd12, 33);
    @(posedge clk_i); #1;
    drive(1'b1, 3'd0, 32'd9, 32'd9, 5'd3);
    repeat (5) @(posedge clk_i);
    #1 flush_i = 1'b1;
    @(posedge clk_i); #1;
    flush_i = 1'b0;
    valid_i = 1'b0;
    activity = 0;
    repeat (40) begin
      @(negedge clk_i);
      if (done_o) activity++;
    end
    chk("flush no done", 32'(activity), 32'd0);
    chk("flush result kept", result_o, 32'd12);
    chk("flush rd kept", 32'(Rd_Addr_o), 32'd15);

    // Reset in the 10th busy cycle clears outputs at once
    @(posedge clk_i); #1;
    drive(1'b1, 3'd0, 32'd3, 32'd5, 5'd9);
    repeat (10) @(posedge clk_i);
    #1 rst_i = 1'b1;
    #1;
    chk("midbusy reset stall_o", 32'(stall_o), 32'd0);
    chk("midbusy reset done_o", 32'(done_o), 32'd0);
    chk("midbusy reset result_o", result_o, 32'd0);
    chk("midbusy reset Rd_Addr_o", 32'(Rd_Addr_o), 32'd0);
    @(posedge clk_i); #1;
    rst_i   = 1'b0;
    valid_i = 1'b0;

    // Randomized instruction stream
    repeat (5000) begin
      @(posedge clk_i); #1;
      valid_i   = ($urandom_range(0, 9) < 7);
      funct_i   = ($urandom_range(0, 4) != 0) ? {7'b0000001, 3'($urandom_range(0, 7))}
                                             : 10'($urandom);
      RS1Data_i = pick();
      RS2Data_i = pick();
      Rd_Addr_i = 5'($urandom);
      flush_i   = ($urandom_range(0, 149) == 0);
      rst_i     = ($urandom_range(0, 1499) == 0);
    end
    @(posedge clk_i); #1;
    rst_i   = 1'b0;
    valid_i = 1'b0;
    flush_i = 1'b0;
    repeat (3) @(posedge clk_i);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ex_muldiv.md
EX_MULDIV -- requirements
Module: ex_muldiv

Interface
REQ-001 SHALL provide port: clk_i  in  1  single clock; all state changes on rising edge.
REQ-002 SHALL provide port: rst_i  in  1  reset, asynchronous, active-high.
REQ-003 SHALL provide port: valid_i  in  1  ID/EX stage holds a valid instruction.
REQ-004 SHALL provide port: flush_i  in  1  abort in-flight op, synchronous.
REQ-005 SHALL provide port: funct_i  in  10  {funct7, funct3} from ID/EX.
REQ-006 SHALL provide port: RS1Data_i  in  32  operand A, dividend.
REQ-007 SHALL provide port: RS2Data_i  in  32  operand B, divisor.
REQ-008 SHALL provide port: Rd_Addr_i  in  5  destination register.
REQ-009 SHALL provide port: stall_o  out  1  hold PC, IF/ID and ID/EX.
REQ-010 SHALL provide port: done_o  out  1  one-cycle result-valid pulse.
REQ-011 SHALL provide port: result_o  out  32  M-extension result.
REQ-012 SHALL provide port: Rd_Addr_o  out  5  destination of result_o.

Function
REQ-013 SHALL decode an M-op when funct_i[9:3]=7'b0000001; funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-014 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-015 SHALL accept on an edge in IDLE with valid_i=1, M-op and flush_i=0: latch operands, op and Rd_Addr_i, clear 5-bit counter, go to BUSY.
REQ-016 SHALL drive stall_o combinationally: 1 in IDLE when acceptance condition is true, 1 in BUSY, 0 in DONE.
REQ-017 SHALL perform one shift-add (mul) or restoring-subtract (div) iteration per BUSY cycle on magnitudes, 32 iterations, then go to DONE.
REQ-018 SHALL assert done_o only in DONE, for exactly one cycle: 33rd cycle after the accepting edge for normal ops.
REQ-019 SHALL apply sign correction for signed ops in the final iteration; MUL returns low 32 bits, MULH/MULHSU/MULHU return high 32 bits of the 64-bit product.
REQ-020 SHALL complete IDLE->DONE in one cycle for divisor 0 (DIV/DIVU quotient 0xFFFFFFFF, REM/REMU = dividend) and for DIV/REM with 0x80000000 / 0xFFFFFFFF (quotient 0x80000000, remainder 0).
REQ-021 SHALL go DONE->IDLE unconditionally and SHALL NOT accept in DONE (instruction still held in ID/EX).
REQ-022 SHALL hold result_o and Rd_Addr_o stable from DONE until the next accept.
REQ-023 SHALL on flush_i=1 in any state return to IDLE next edge, no done_o, result_o unchanged; flush wins over accept.
REQ-024 SHALL ignore non-M instructions and valid_i=0: stall_o=0, state unchanged.

Reset
REQ-025 SHALL on rst_i=1 immediately force IDLE, counter 0, stall_o=0, done_o=0, result_o=0, Rd_Addr_o=0, including mid-BUSY.
REQ-026 SHALL after rst_i deassertion accept no op before the first rising edge.

Configuration
REQ-027 SHALL with MULDIV_DIV_EN defined implement all eight ops as above.
REQ-028 SHALL without MULDIV_DIV_EN omit divider datapath; funct3[2]=1 ops treated as non-M (stall_o=0, no done_o, result_o unchanged).

Verification
REQ-029 SHALL cover: MUL 7 x 6 -> stall_o 1 for 33 cycles, done_o at cycle 33, result_o=42.
REQ-030 SHALL cover: MULH 0xFFFFFFFF x 0xFFFFFFFF -> 0x00000000; MULHU same operands -> 0xFFFFFFFE.
REQ-031 SHALL cover: DIV -7 / 2 -> 0xFFFFFFFD; REM -7 / 2 -> 0xFFFFFFFF; DIVU 100 / 0 -> 0xFFFFFFFF after 1 cycle.
REQ-032 SHALL cover: DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000, done_o one cycle after accept.
REQ-033 SHALL cover: rst_i pulse at BUSY cycle 10 -> all outputs 0 at once; flush_i at cycle 5 -> IDLE, no done_o.
REQ-034 SHALL cover: build without MULDIV_DIV_EN, DIV 10/2 -> stall_o stays 0, done_o never asserted.
